cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 39 +++
 rtl/cpu_ctrl_jump_unit.sv | 21 ++
 rtl/cpu_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_ctrl_pkg                                               |
// | Description : Shared types and constants for the cpu_ctrl sequencer:     |
// |               FSM state encoding, instruction field bit positions and   |
// |               the 4-bit datapath width.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cpu_ctrl_pkg;

  localparam int C_DATA_W  = 4;
  localparam int C_INSTR_W = 16;

  // Instruction field positions
  localparam int C_BIT_CTYPE = 15;  // 1 = compute (C-type), 0 = load-A (A-type)
  localparam int C_BIT_ABIT  = 12;  // ALU y operand: 1 = mem_in, 0 = A
  localparam int C_CTRL_MSB  = 11;  // {zx,nx,zy,ny,f,no}
  localparam int C_CTRL_LSB  = 6;
  localparam int C_DEST_A    = 5;
  localparam int C_DEST_D    = 4;
  localparam int C_DEST_M    = 3;
  localparam int C_JMP_MSB   = 2;   // {j1,j2,j3}
  localparam int C_JMP_LSB   = 0;
  localparam int C_DATA_MSB  = 3;   // A-type immediate
  localparam int C_DATA_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Program counter increment; the carry out of the top bit is dropped.
  function automatic logic [C_DATA_W-1:0] inc_wrap(input logic [C_DATA_W-1:0] v);
    return v + {{(C_DATA_W-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_jump_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : jump_unit                                                  |
// | Description : Combinational branch condition.                            |
// |               i_j  [2:0] : jump bits {j1 (neg), j2 (zero), j3 (pos)}     |
// |               i_zr       : registered ALU zero flag                      |
// |               i_ng       : registered ALU negative flag                  |
// |               o_jmp      : take the branch                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module jump_unit (
  input  logic [2:0] i_j,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_jmp
);

  assign o_jmp = (i_j[2] & i_ng) | (i_j[1] & i_zr) | (i_j[0] & ~i_ng & ~i_zr);

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_ctrl                                                   |
// | Description : Three-state (IDLE/EXEC/WB) control sequencer for a 4-bit   |
// |               Hack-style CPU. The ALU is external and reached only via   |
// |               the alu_* ports.                                           |
// |   clk, rst_n            : clock, async active-low reset                  |
// |   instr/instr_valid/    : instruction handshake (ready only in IDLE)     |
// |   instr_ready                                                            |
// |   alu_x/alu_y/alu_ctrl  : operands and control to the ALU (0 off-EXEC)   |
// |   alu_out/alu_zr/alu_ng : ALU result and flags                           |
// |   mem_in/mem_addr/      : data memory port, mem_addr = A                 |
// |   mem_wdata/mem_we                                                       |
// |   pc/a_reg/d_reg        : architectural state                            |
// | Optional    : CPU_CTRL_HALT_EN adds input halt, which stalls the         |
// |               sequencer in IDLE only.                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cpu_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [C_INSTR_W-1:0]  instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [C_DATA_W-1:0]   alu_x,
  output logic [C_DATA_W-1:0]   alu_y,
  output logic [5:0]            alu_ctrl,
  input  logic [C_DATA_W-1:0]   alu_out,
  input  logic                  alu_zr,
  input  logic                  alu_ng,
  input  logic [C_DATA_W-1:0]   mem_in,
  output logic [C_DATA_W-1:0]   mem_addr,
  output logic [C_DATA_W-1:0]   mem_wdata,
  output logic                  mem_we,
  output logic [C_DATA_W-1:0]   pc,
  output logic [C_DATA_W-1:0]   a_reg,
`ifdef CPU_CTRL_HALT_EN
  input  logic                  halt,
`endif
  output logic [C_DATA_W-1:0]   d_reg
);

  state_t                r_state;
  logic                  r_ctype;
  logic [12:0]           r_instr;   // bits 14:13 carry no meaning and are not kept
  logic [C_DATA_W-1:0]   r_pc;
  logic [C_DATA_W-1:0]   r_a;
  logic [C_DATA_W-1:0]   r_d;
  logic [C_DATA_W-1:0]   r_result;
  logic                  r_zr;
  logic                  r_ng;
  logic                  r_mem_we;

  logic                  w_ready;
  logic                  w_take;
  logic                  w_jmp;
  logic [C_DATA_W-1:0]   w_pc_inc;
  logic                  w_unused;

  assign w_unused = &{1'b0, instr[14:13]};

`ifdef CPU_CTRL_HALT_EN
  assign w_ready = (r_state == ST_IDLE) & ~halt;
`else
  assign w_ready = (r_state == ST_IDLE);
`endif

  assign w_take   = w_ready & instr_valid;
  assign w_pc_inc = inc_wrap(r_pc);

  jump_unit u_jump_unit (
    .i_j   (r_instr[C_JMP_MSB:C_JMP_LSB]),
    .i_zr  (r_zr),
    .i_ng  (r_ng),
    .o_jmp (w_jmp)
  );

  // ALU operands are driven only while executing so the ALU sees idle zeros
  // at all other times.
  always_comb begin
    alu_x    = '0;
    alu_y    = '0;
    alu_ctrl = '0;
    if (r_state == ST_EXEC) begin
      alu_x    = r_d;
      alu_y    = r_instr[C_BIT_ABIT] ? mem_in : r_a;
      alu_ctrl = r_instr[C_CTRL_MSB:C_CTRL_LSB];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ctype  <= 1'b0;
      r_instr  <= '0;
      r_pc     <= '0;
      r_a      <= '0;
      r_d      <= '0;
      r_result <= '0;
      r_zr     <= 1'b0;
      r_ng     <= 1'b0;
      r_mem_we <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_ctype <= instr[C_BIT_CTYPE];
            r_instr <= instr[12:0];
            r_state <= instr[C_BIT_CTYPE] ? ST_EXEC : ST_WB;
          end
        end
        ST_EXEC: begin
          r_result <= alu_out;
          r_zr     <= alu_zr;
          r_ng     <= alu_ng;
          // Write strobe is raised for the WB cycle only; mem_addr is still
          // the pre-writeback A during that cycle.
          r_mem_we <= r_instr[C_DEST_M];
          r_state  <= ST_WB;
        end
        ST_WB: begin
          r_mem_we <= 1'b0;
          if (r_ctype) begin
            if (r_instr[C_DEST_A]) r_a <= r_result;
            if (r_instr[C_DEST_D]) r_d <= r_result;
            // r_a here is the value before this writeback, so a jump with
            // dest A still targets the old A.
            r_pc <= w_jmp ? r_a : w_pc_inc;
          end else begin
            r_a  <= r_instr[C_DATA_MSB:C_DATA_LSB];
            r_pc <= w_pc_inc;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = w_ready;
  assign mem_addr    = r_a;
  assign mem_wdata   = r_result;
  assign mem_we      = r_mem_we;
  assign pc          = r_pc;
  assign a_reg       = r_a;
  assign d_reg       = r_d;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cpu_ctrl                                                |
// | Description : Self-checking bench for cpu_ctrl with a behavioural ALU.   |
// |               Table-driven instruction vectors plus reset-abort and      |
// |               idle-hold sequences.                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  alu_x, alu_y;
  logic [5:0]  alu_ctrl;
  logic [3:0]  alu_out;
  logic        alu_zr, alu_ng;
  logic [3:0]  mem_in, mem_addr, mem_wdata;
  logic        mem_we;
  logic [3:0]  pc, a_reg, d_reg;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_ctrl    (alu_ctrl),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .mem_in      (mem_in),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .pc          (pc),
    .a_reg       (a_reg),
    .d_reg       (d_reg)
  );

  // Behavioural Hack ALU, ctrl = {zx,nx,zy,ny,f,no}
  logic [3:0] bx, by, bo;
  always_comb begin
    bx = alu_ctrl[5] ? 4'h0 : alu_x;
    if (alu_ctrl[4]) bx = ~bx;
    by = alu_ctrl[3] ? 4'h0 : alu_y;
    if (alu_ctrl[2]) by = ~by;
    bo = alu_ctrl[1] ? (bx + by) : (bx & by);
    if (alu_ctrl[0]) bo = ~bo;
  end
  assign alu_out = bo;
  assign alu_zr  = (bo == 4'h0);
  assign alu_ng  = bo[3];

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  mem_in;
    logic [3:0]  ex_x;
    logic [3:0]  ex_y;
    logic [3:0]  ex_a;
    logic [3:0]  ex_d;
    logic [3:0]  ex_pc;
    logic        ex_we;
    logic [3:0]  ex_waddr;
    logic [3:0]  ex_wdata;
  } vec_t;

  function automatic logic [15:0] ci(input logic a, input logic [5:0] c,
                                     input logic [2:0] d, input logic [2:0] j);
    return {3'b111, a, c, d, j};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for IDLE, then present one instruction for a single handshake.
  task automatic issue(input logic [15:0] ins, input logic [3:0] mi, input string nm);
    int waitc = 0;
    @(negedge clk);
    while (!instr_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    chk({nm, " ready_at_issue"}, instr_ready, 1'b1);
    mem_in      = mi;
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    string nm;
    nm = $sformatf("v%0d", idx);
    issue(t.instr, t.mem_in, nm);
    if (t.instr[15]) begin
      @(negedge clk);  // EXEC
      chk({nm, " alu_x"},    alu_x,    t.ex_x);
      chk({nm, " alu_y"},    alu_y,    t.ex_y);
      chk({nm, " alu_ctrl"}, alu_ctrl, t.instr[11:6]);
      chk({nm, " we_exec"},  mem_we,   1'b0);
      @(posedge clk);
    end
    @(negedge clk);    // WB
    chk({nm, " we_wb"},    mem_we,   t.ex_we);
    chk({nm, " ctrl_wb"},  alu_ctrl, 6'h00);
    if (t.ex_we) begin
      chk({nm, " mem_addr"},  mem_addr,  t.ex_waddr);
      chk({nm, " mem_wdata"}, mem_wdata, t.ex_wdata);
    end
    @(posedge clk);
    @(negedge clk);    // back in IDLE
    chk({nm, " a"},     a_reg,       t.ex_a);
    chk({nm, " d"},     d_reg,       t.ex_d);
    chk({nm, " pc"},    pc,          t.ex_pc);
    chk({nm, " ready"}, instr_ready, 1'b1);
    chk({nm, " we_idle"}, mem_we,    1'b0);
  endtask

  vec_t v[21];
  vec_t h;

  initial begin
    //        instr                          mi    x     y     A     D     pc    we  addr  wdata
    v[0]  = '{16'h0005,                      4'h0, 4'h0, 4'h0, 4'h5, 4'h0, 4'h1, 1'b0, 4'h0, 4'h0};
    v[1]  = '{16'h0FF3,                      4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h2, 1'b0, 4'h0, 4'h0};
    v[2]  = '{ci(0, 6'b110000, 3'b010, 3'b000), 4'h0, 4'h0, 4'h3, 4'h3, 4'h3, 4'h3, 1'b0, 4'h0, 4'h0};
    v[3]  = '{ci(0, 6'b000010, 3'b010, 3'b000), 4'h0, 4'h3, 4'h3, 4'h3, 4'h6, 4'h4, 1'b0, 4'h0, 4'h0};
    v[4]  = '{16'h0007,                      4'h0, 4'h0, 4'h0, 4'h7, 4'h6, 4'h5, 1'b0, 4'h0, 4'h0};
    v[5]  = '{ci(1, 6'b110111, 3'b001, 3'b000), 4'h2, 4'h6, 4'h2, 4'h7, 4'h6, 4'h6, 1'b1, 4'h7, 4'h3};
    v[6]  = '{16'h0009,                      4'h0, 4'h0, 4'h0, 4'h9, 4'h6, 4'h7, 1'b0, 4'h0, 4'h0};
    v[7]  = '{ci(0, 6'b101010, 3'b010, 3'b000), 4'h0, 4'h6, 4'h9, 4'h9, 4'h0, 4'h8, 1'b0, 4'h0, 4'h0};
    v[8]  = '{ci(0, 6'b001100, 3'b000, 3'b010), 4'h0, 4'h0, 4'h9, 4'h9, 4'h0, 4'h9, 1'b0, 4'h0, 4'h0};
    v[9]  = '{ci(0, 6'b111111, 3'b010, 3'b000), 4'h0, 4'h0, 4'h9, 4'h9, 4'h1, 4'hA, 1'b0, 4'h0, 4'h0};
    v[10] = '{ci(0, 6'b001100, 3'b000, 3'b010), 4'h0, 4'h1, 4'h9, 4'h9, 4'h1, 4'hB, 1'b0, 4'h0, 4'h0};
    v[11] = '{16'h0004,                      4'h0, 4'h0, 4'h0, 4'h4, 4'h1, 4'hC, 1'b0, 4'h0, 4'h0};
    v[12] = '{ci(0, 6'b111010, 3'b100, 3'b111), 4'h0, 4'h1, 4'h4, 4'hF, 4'h1, 4'h4, 1'b0, 4'h0, 4'h0};
    v[13] = '{16'h000F,                      4'h0, 4'h0, 4'h0, 4'hF, 4'h1, 4'h5, 1'b0, 4'h0, 4'h0};
    v[14] = '{ci(0, 6'b101010, 3'b000, 3'b111), 4'h0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h0, 4'h0};
    v[15] = '{ci(0, 6'b001100, 3'b000, 3'b010), 4'h0, 4'h1, 4'hF, 4'hF, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0};
    v[16] = '{ci(0, 6'b111010, 3'b010, 3'b000), 4'h0, 4'h1, 4'hF, 4'hF, 4'hF, 4'h1, 1'b0, 4'h0, 4'h0};
    v[17] = '{16'h0008,                      4'h0, 4'h0, 4'h0, 4'h8, 4'hF, 4'h2, 1'b0, 4'h0, 4'h0};
    v[18] = '{ci(0, 6'b001100, 3'b000, 3'b100), 4'h0, 4'hF, 4'h8, 4'h8, 4'hF, 4'h8, 1'b0, 4'h0, 4'h0};
    v[19] = '{ci(0, 6'b001100, 3'b000, 3'b001), 4'h0, 4'hF, 4'h8, 4'h8, 4'hF, 4'h9, 1'b0, 4'h0, 4'h0};
    v[20] = '{ci(0, 6'b011111, 3'b111, 3'b000), 4'h0, 4'hF, 4'h8, 4'h0, 4'h0, 4'hA, 1'b1, 4'h8, 4'h0};

    rst_n       = 1'b0;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    mem_in      = 4'h0;

    // Reset state
    #1;
    chk("rst pc",    pc,          4'h0);
    chk("rst a",     a_reg,       4'h0);
    chk("rst d",     d_reg,       4'h0);
    chk("rst we",    mem_we,      1'b0);
    chk("rst ready", instr_ready, 1'b1);
    chk("rst ctrl",  alu_ctrl,    6'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) run_vec(v[i], i);

    // Idle hold: no handshake, nothing moves
    repeat (5) @(negedge clk);
    chk("hold pc",    pc,          4'hA);
    chk("hold a",     a_reg,       4'h0);
    chk("hold ready", instr_ready, 1'b1);
    chk("hold alu_x", alu_x,       4'h0);
    chk("hold alu_y", alu_y,       4'h0);

    // Reset during EXEC aborts the instruction
    h = '{16'h0006, 4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 4'hB, 1'b0, 4'h0, 4'h0};
    run_vec(h, 100);
    h = '{ci(0, 6'b110000, 3'b010, 3'b000), 4'h0, 4'h0, 4'h6, 4'h6, 4'h6, 4'hC, 1'b0, 4'h0, 4'h0};
    run_vec(h, 101);
    issue(ci(0, 6'b011111, 3'b111, 3'b111), 4'h0, "rexec");
    @(negedge clk);
    chk("rexec in_exec ctrl", alu_ctrl, 6'b011111);
    rst_n = 1'b0;
    #1;
    chk("rexec pc",    pc,          4'h0);
    chk("rexec a",     a_reg,       4'h0);
    chk("rexec d",     d_reg,       4'h0);
    chk("rexec we",    mem_we,      1'b0);
    chk("rexec ready", instr_ready, 1'b1);
    chk("rexec ctrl",  alu_ctrl,    6'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during a memory-writing WB aborts the write
    h = '{16'h0005, 4'h0, 4'h0, 4'h0, 4'h5, 4'h0, 4'h1, 1'b0, 4'h0, 4'h0};
    run_vec(h, 102);
    h = '{ci(0, 6'b110000, 3'b010, 3'b000), 4'h0, 4'h0, 4'h5, 4'h5, 4'h5, 4'h2, 1'b0, 4'h0, 4'h0};
    run_vec(h, 103);
    issue(ci(0, 6'b011111, 3'b101, 3'b111), 4'h0, "rwb");
    @(posedge clk);
    @(negedge clk);
    chk("rwb we_before", mem_we,    1'b1);
    chk("rwb wdata",     mem_wdata, 4'h6);
    chk("rwb addr",      mem_addr,  4'h5);
    rst_n = 1'b0;
    #1;
    chk("rwb we",    mem_we,      1'b0);
    chk("rwb pc",    pc,          4'h0);
    chk("rwb a",     a_reg,       4'h0);
    chk("rwb d",     d_reg,       4'h0);
    chk("rwb ready", instr_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rwb post pc", pc, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
